// File: rtl/inst_rom_server_pkg.sv
// Shared definitions for the instruction ROM server: bus widths, constants and FSM encoding.
package inst_rom_server_pkg;

    localparam int INST_BUS_W      = 32;
    localparam int INST_ADDR_BUS_W = 32;

    typedef logic [INST_BUS_W-1:0]      inst_t;
    typedef logic [INST_ADDR_BUS_W-1:0] inst_addr_t;

    localparam inst_t ZERO_WORD    = '0;
    localparam logic  CHIP_ENABLE  = 1'b1;
    localparam logic  CHIP_DISABLE = 1'b0;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic is_misaligned(input inst_addr_t addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_rom_server_if.sv
// Fetch port plus boot-loader stream of the instruction ROM server, seen from both ends.
interface inst_rom_server_if #(
    parameter int ADDR_W = 10
);
    import inst_rom_server_pkg::*;

    logic              rom_ce_i;
    inst_addr_t        rom_addr_i;
    inst_t             rom_data_o;
    logic              load_valid_i;
    logic              load_ready_o;
    inst_t             load_data_i;
    logic              load_last_i;
    logic              reload_i;
    logic              boot_done_o;
    logic [ADDR_W:0]   load_count_o;
    logic              err_range_o;
    logic              err_misalign_o;

    modport master (
        output rom_ce_i, rom_addr_i, load_valid_i, load_data_i, load_last_i, reload_i,
        input  rom_data_o, load_ready_o, boot_done_o, load_count_o, err_range_o, err_misalign_o
    );

    modport slave (
        input  rom_ce_i, rom_addr_i, load_valid_i, load_data_i, load_last_i, reload_i,
        output rom_data_o, load_ready_o, boot_done_o, load_count_o, err_range_o, err_misalign_o
    );

endinterface

// File: rtl/inst_rom_server_mem_array.sv
// Program storage: one synchronous write port, one asynchronous read port.
module inst_mem_array
    import inst_rom_server_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  inst_t             wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output inst_t             rdata_o
);

    inst_t mem_q [2**ADDR_W];

    // NOTE: storage arrays get no reset; contents survive a reset and are simply overwritten by the next load.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_rom_server.sv
// Instruction ROM server: boot-time image loader FSM, zero-latency fetch path and sticky fetch error flags.
module inst_rom_server
    import inst_rom_server_pkg::*;
#(
    parameter int    ADDR_W   = 10,
    parameter inst_t NOP_INST = ZERO_WORD
) (
    input  logic             clk,
    input  logic             rst,
    inst_rom_server_if.slave bus
);

    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PTR_LAST  = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_range_q, err_range_d;
    logic              err_misalign_q, err_misalign_d;

    logic              accept;
    logic              load_done;
    logic              fetch_run;
    logic              in_range;
    logic [ADDR_W-1:0] word_idx;
    inst_t             rd_data;

    assign word_idx  = bus.rom_addr_i[ADDR_W+1:2];
    assign in_range  = (bus.rom_addr_i[INST_ADDR_BUS_W-1:ADDR_W+2] == '0);
    assign accept    = (state_q == ST_LOAD) && bus.load_valid_i;
    // The image ends on an explicit last flag or when the final slot is filled.
    assign load_done = accept && (bus.load_last_i || (ptr_q == PTR_LAST));
    assign fetch_run = (state_q == ST_RUN) && (bus.rom_ce_i == CHIP_ENABLE);

    inst_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (ptr_q),
        .wdata_i (bus.load_data_i),
        .raddr_i (word_idx),
        .rdata_o (rd_data)
    );

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: if (load_done)    state_d = ST_RUN;
            ST_RUN:  if (bus.reload_i) state_d = ST_LOAD;
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        bus.load_ready_o = (state_q == ST_LOAD);
        bus.boot_done_o  = (state_q == ST_RUN);
        bus.rom_data_o   = (fetch_run && in_range) ? rd_data : NOP_INST;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q          <= '0;
            count_q        <= '0;
            err_range_q    <= 1'b0;
            err_misalign_q <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            count_q        <= count_d;
            err_range_q    <= err_range_d;
            err_misalign_q <= err_misalign_d;
        end
    end

    always_comb begin
        ptr_d          = ptr_q;
        count_d        = count_q;
        err_range_d    = err_range_q;
        err_misalign_d = err_misalign_q;

        if (accept) begin
            ptr_d = ptr_q + 1'b1;
            if (count_q != COUNT_MAX) begin
                count_d = count_q + 1'b1;
            end
        end

        if ((state_q == ST_RUN) && bus.reload_i) begin
            ptr_d   = '0;
            count_d = '0;
        end

        // Error flags are sticky until reset, including across reloads.
        if (fetch_run) begin
            if (!in_range)                       err_range_d    = 1'b1;
            if (is_misaligned(bus.rom_addr_i))   err_misalign_d = 1'b1;
        end
    end

    assign bus.load_count_o   = count_q;
    assign bus.err_range_o    = err_range_q;
    assign bus.err_misalign_o = err_misalign_q;

endmodule

// File: tb/tb_inst_rom_server.sv
// Bench for inst_rom_server: two instances (ADDR_W=10 and ADDR_W=4) driven in lockstep against a behavioural model.
module tb_inst_rom_server;
    import inst_rom_server_pkg::*;

    localparam int AW_A = 10;
    localparam int AW_B = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_rom_server_if #(.ADDR_W(AW_A)) bus_a ();
    inst_rom_server_if #(.ADDR_W(AW_B)) bus_b ();

    inst_rom_server #(.ADDR_W(AW_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    inst_rom_server #(.ADDR_W(AW_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    // Behavioural model: index 0 tracks dut_a, index 1 tracks dut_b.
    int          aw [2] = '{AW_A, AW_B};
    bit          m_run [2];
    int          m_ptr [2];
    int          m_cnt [2];
    bit          m_rng [2];
    bit          m_mis [2];
    logic [31:0] mem_a [int];
    logic [31:0] mem_b [int];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit ce, input logic [31:0] addr, input bit valid,
                         input logic [31:0] data, input bit last, input bit reload);
        bus_a.rom_ce_i = ce;     bus_b.rom_ce_i = ce;
        bus_a.rom_addr_i = addr; bus_b.rom_addr_i = addr;
        bus_a.load_valid_i = valid; bus_b.load_valid_i = valid;
        bus_a.load_data_i = data;   bus_b.load_data_i = data;
        bus_a.load_last_i = last;   bus_b.load_last_i = last;
        bus_a.reload_i = reload;    bus_b.reload_i = reload;
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_run[w] = 0; m_ptr[w] = 0; m_cnt[w] = 0; m_rng[w] = 0; m_mis[w] = 0;
        end
    endtask

    // Apply the documented edge behaviour for one accepted clock edge.
    task automatic model_step(input int w, input bit ce, input logic [31:0] addr, input bit valid,
                              input logic [31:0] data, input bit last, input bit reload);
        int depth = 1 << aw[w];
        if (!m_run[w]) begin
            if (valid) begin
                bit final_slot = (m_ptr[w] == depth - 1);
                if (w == 0) mem_a[m_ptr[w]] = data; else mem_b[m_ptr[w]] = data;
                m_ptr[w] = (m_ptr[w] + 1) % depth;
                if (m_cnt[w] < depth) m_cnt[w]++;
                if (last || final_slot) m_run[w] = 1;
            end
        end else begin
            if (ce) begin
                if ((addr >> (aw[w] + 2)) != 0) m_rng[w] = 1;
                if (addr[1:0] != 2'b00)         m_mis[w] = 1;
            end
            if (reload) begin
                m_run[w] = 0; m_ptr[w] = 0; m_cnt[w] = 0;
            end
        end
    endtask

    task automatic get_outs(input int w, output logic [31:0] rd, output logic rdy, output logic boot,
                            output logic rng, output logic mis, output logic [63:0] cnt);
        if (w == 0) begin
            rd = bus_a.rom_data_o; rdy = bus_a.load_ready_o; boot = bus_a.boot_done_o;
            rng = bus_a.err_range_o; mis = bus_a.err_misalign_o; cnt = 64'(bus_a.load_count_o);
        end else begin
            rd = bus_b.rom_data_o; rdy = bus_b.load_ready_o; boot = bus_b.boot_done_o;
            rng = bus_b.err_range_o; mis = bus_b.err_misalign_o; cnt = 64'(bus_b.load_count_o);
        end
    endtask

    task automatic check_state(input int w);
        logic [31:0] rd; logic rdy, boot, rng, mis; logic [63:0] cnt;
        get_outs(w, rd, rdy, boot, rng, mis, cnt);
        check($sformatf("ready_aw%0d", aw[w]),    64'(rdy),  64'(!m_run[w]));
        check($sformatf("boot_aw%0d", aw[w]),     64'(boot), 64'(m_run[w]));
        check($sformatf("count_aw%0d", aw[w]),    cnt,       64'(m_cnt[w]));
        check($sformatf("err_rng_aw%0d", aw[w]),  64'(rng),  64'(m_rng[w]));
        check($sformatf("err_mis_aw%0d", aw[w]),  64'(mis),  64'(m_mis[w]));
    endtask

    task automatic check_fetch(input int w, input bit ce, input logic [31:0] addr);
        logic [31:0] rd; logic rdy, boot, rng, mis; logic [63:0] cnt;
        int depth = 1 << aw[w];
        get_outs(w, rd, rdy, boot, rng, mis, cnt);
        if (ce && m_run[w] && ((addr >> (aw[w] + 2)) == 0)) begin
            int idx = int'((addr >> 2) % depth);
            if (w == 0 && mem_a.exists(idx))
                check($sformatf("fetch_aw%0d_%0h", aw[w], addr), 64'(rd), 64'(mem_a[idx]));
            else if (w == 1 && mem_b.exists(idx))
                check($sformatf("fetch_aw%0d_%0h", aw[w], addr), 64'(rd), 64'(mem_b[idx]));
        end else begin
            check($sformatf("nop_aw%0d_%0h", aw[w], addr), 64'(rd), 64'h0);
        end
    endtask

    task automatic cycle(input bit ce, input logic [31:0] addr, input bit valid,
                         input logic [31:0] data, input bit last, input bit reload);
        drive(ce, addr, valid, data, last, reload);
        #1;
        for (int w = 0; w < 2; w++) check_fetch(w, ce, addr);
        @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            model_step(w, ce, addr, valid, data, last, reload);
            check_state(w);
        end
    endtask

    initial begin
        bit          v, l, r, c;
        logic [31:0] a;

        // Reset state, with a live fetch request that must still return NOP.
        rst = 1'b0;
        model_reset();
        drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        for (int w = 0; w < 2; w++) begin
            check_state(w);
            check_fetch(w, 1'b1, 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Boot image of four words, last flag on the fourth.
        for (int i = 1; i <= 4; i++)
            cycle(1'b0, 32'h0, 1'b1, 32'h3401_0000 + 32'(i), i == 4, 1'b0);
        check("boot_after_word4", 64'(bus_a.boot_done_o), 64'h1);
        check("count_after_word4", 64'(bus_a.load_count_o), 64'd4);

        // Same-cycle fetches, then chip disabled, and a late valid that RUN must ignore.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h8, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);

        // Reload with a fetch in the same cycle; then 20 words with no last flag.
        cycle(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            cycle(1'b0, 32'h0, 1'b1, 32'hA500_0000 + 32'(i), 1'b0, 1'b0);
        check("aw4_saturated_count", 64'(bus_b.load_count_o), 64'd16);
        check("aw4_ready_low", 64'(bus_b.load_ready_o), 64'h0);
        cycle(1'b0, 32'h0, 1'b1, 32'hA500_0014, 1'b1, 1'b0);

        // Out-of-range and misaligned fetches; flags must survive a reload.
        cycle(1'b1, 32'h0000_1000, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0006, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Loader with gaps; only handshake cycles write.
        for (int i = 0; i < 10; i++) begin
            v = (i % 3) != 1;
            cycle(1'b1, 32'h0, v, 32'hC000_0000 + 32'(i), i == 9, 1'b0);
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0);

        // Reload, two words, then an asynchronous reset in the middle of the stream.
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 32'h7700_0001, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 32'h7700_0002, 1'b0, 1'b0);
        drive(1'b1, 32'h0, 1'b1, 32'h7700_0003, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        for (int w = 0; w < 2; w++) begin
            check_state(w);
            check_fetch(w, 1'b1, 32'h0);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 32'h0, 1'b1, 32'h9900_0000, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 32'h9900_0001, 1'b1, 1'b0);
        cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 3) != 0);
            a = 32'($urandom_range(0, 31)) << 2;
            if ($urandom_range(0, 7) == 0)  a[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(12, 31));
            v = $urandom_range(0, 1) == 1;
            l = $urandom_range(0, 11) == 0;
            r = $urandom_range(0, 19) == 0;
            cycle(c, a, v, $urandom, l, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_rom_server.md
Name: inst_rom_server

Overview:
Responder end of the CPU instruction-fetch interface (rom_ce / rom_addr / rom_data). It holds program memory in a word array, loaded at boot through a valid/ready stream. It serves fetches combinationally so the fetch stage latches data in the same cycle as the PC. boot_done_o signals when the image is resident; the system uses it to release the CPU core from reset.

Parameters:
ADDR_W, 10, word-index width; memory holds DEPTH = 2**ADDR_W 32-bit words
NOP_INST, 32'h0000_0000, value returned when no valid instruction is available

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
rom_ce_i  input  1  fetch enable from CPU
rom_addr_i  input  32  fetch byte address; word index = rom_addr_i[ADDR_W+1:2]
rom_data_o  output  32  fetched instruction
load_valid_i  input  1  loader word valid
load_ready_o  output  1  loader word accepted when valid & ready
load_data_i  input  32  loader word
load_last_i  input  1  marks final word of image
reload_i  input  1  single-cycle request to re-enter LOAD from RUN
boot_done_o  output  1  image resident; fetches served
load_count_o  output  ADDR_W+1  number of words written in current/last load
err_range_o  output  1  sticky: a fetch in RUN addressed beyond DEPTH words
err_misalign_o  output  1  sticky: a fetch in RUN had rom_addr_i[1:0] != 0

Behaviour:
- Reset (rst=0, asynchronous): state=LOAD, write pointer=0, load_count_o=0, load_ready_o=1, boot_done_o=0, both error flags=0. Memory contents are not cleared. rom_data_o=NOP_INST.
- Two-state FSM, LOAD and RUN:
  - In LOAD, load_ready_o=1.
  - Handshake (load_valid_i & load_ready_o): write mem[ptr]=load_data_i, then ptr+1 and load_count_o+1 on the same edge.
  - Transition LOAD->RUN on the edge that accepts a word with load_last_i=1, or the edge that accepts the word at ptr=DEPTH-1, whichever comes first.
  - At that edge load_ready_o becomes 0 and boot_done_o becomes 1.
  - A load_last_i with load_valid_i=0 has no effect.
- In RUN:
  - load_ready_o=0; load_valid_i is ignored and memory is not written.
  - reload_i=1 moves to LOAD at the next edge: ptr=0, load_count_o=0, boot_done_o=0, load_ready_o=1. Error flags are kept.
  - A reload_i in LOAD is ignored.
- Fetch path (combinational, zero latency):
  - rom_data_o = mem[word index] when rom_ce_i=1, state=RUN and rom_addr_i[31:ADDR_W+2]==0.
  - Otherwise rom_data_o = NOP_INST.
  - Misaligned addresses use the word index with the low two bits dropped.
- Errors (RUN only, rom_ce_i=1):
  - err_range_o is set at the edge following a fetch with upper address bits nonzero.
  - err_misalign_o is set at the edge following a fetch with rom_addr_i[1:0]!=0.
  - Both flags clear only on reset.
- Simultaneous events:
  - reload_i with a fetch in the same RUN cycle: the fetch is served normally; the state changes at the edge.
  - Reads and writes never coexist (state-exclusive), so no read-during-write rule is needed.
- Reset mid-load: ptr and count return to 0 and the load restarts; partially written words remain until overwritten.
- load_count_o saturates at DEPTH (width ADDR_W+1) and never wraps.

Decomposition:
- Shared defines file (existing global defines):
  - word width (InstBus)
  - address width (InstAddrBus)
  - ZeroWord / NOP constant
  - FSM state encoding constants: StLoad, StRun
  - ChipEnable / ChipDisable
- One sub-module, inst_mem_array: DEPTH x 32 storage, one synchronous write port, one asynchronous read port, no reset.
- The FSM, counters and error flags live in inst_rom_server.

Test Plan:
- Reset, then stream 4 words 32'h3401_0001..32'h3401_0004 with last on word 4 -> load_count_o=4; boot_done_o=1 on the edge accepting word 4; load_ready_o=0 after it.
- In RUN, fetch rom_addr_i=0,4,8,12 with rom_ce_i=1 -> rom_data_o = 32'h3401_0001..04 in the same cycle. With rom_ce_i=0 -> rom_data_o=0.
- Fetch during LOAD (rom_ce_i=1, addr 0) -> rom_data_o=0. Toggle load_valid_i with gaps -> only handshake cycles write; count matches accepted words.
- ADDR_W=4: stream 20 words without last -> LOAD->RUN after word 16; load_count_o=16; words 17-20 not accepted (ready=0).
- In RUN, fetch addr 32'h0000_1000 (ADDR_W=10) -> data=0, err_range_o=1 next edge. Fetch addr 6 -> returns word 1, err_misalign_o=1. Both flags stay set through reload.
- Assert reload_i, load 2 new words, then drop rst to 0 mid-stream -> outputs go immediately to reset values; a reload after reset starts at ptr=0.
